// File: rtl/alu_link_host_if.sv
// Request/result and UART byte-stream signals of the ALU link host.
interface alu_link_host_if;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] res;
   logic        overflow;
   logic        timeout;
   logic        proto_err;
   logic [7:0]  TXbuffer;
   logic        TXstart;
   logic        TXbusy;
   logic [7:0]  RXbuffer;
   logic        RXready;

   modport slave (
      input  start, op, a, b, TXbusy, RXbuffer, RXready,
      output busy, done, res, overflow, timeout, proto_err, TXbuffer, TXstart
   );

   modport master (
      output start, op, a, b, TXbusy, RXbuffer, RXready,
      input  busy, done, res, overflow, timeout, proto_err, TXbuffer, TXstart
   );
endinterface

// File: rtl/alu_link_host.sv
// Host side of a UART-linked remote ALU: ships a 5-byte request {op, a, b},
// then collects a 3-byte reply {res_lo, res_hi, flags} under an idle timeout.
module alu_link_host #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
   input  logic           clk,
   input  logic           rst,
   alu_link_host_if.slave bus
);
   localparam int unsigned CNT_W    = 24;
   localparam int unsigned TX_IDX_W = 3;
   localparam int unsigned RX_IDX_W = 2;
   localparam int unsigned GUARD_W  = 2;
   localparam logic [TX_IDX_W-1:0] TX_LAST    = TX_IDX_W'(4);
   localparam logic [RX_IDX_W-1:0] RX_LAST    = RX_IDX_W'(2);
   localparam logic [GUARD_W-1:0]  TX_GUARD   = GUARD_W'(2);
   localparam logic [CNT_W-1:0]    IDLE_LIMIT = TIMEOUT_CYCLES - CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND   = 3'd1,
      TXWAIT = 3'd2,
      RECV   = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [15:0]           a_q, a_d;
   logic [15:0]           b_q, b_d;
   logic [TX_IDX_W-1:0]   tx_idx_q, tx_idx_d;
   logic [GUARD_W-1:0]    tx_guard_q, tx_guard_d;
   logic [RX_IDX_W-1:0]   rx_idx_q, rx_idx_d;
   logic [7:0]            rx_lo_q, rx_lo_d;
   logic [7:0]            rx_hi_q, rx_hi_d;
   logic [CNT_W-1:0]      idle_q, idle_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [15:0]           res_q, res_d;
   logic                  overflow_q, overflow_d;
   logic                  timeout_q, timeout_d;
   logic                  proto_err_q, proto_err_d;
   logic [7:0]            txbuf_q, txbuf_d;
   logic                  txstart_q, txstart_d;
   logic [7:0]            tx_byte;

   // Request byte selected by the current send position.
   always_comb begin
      tx_byte = 8'h00;
      case (tx_idx_q)
         3'd0:    tx_byte = {6'b0, op_q};
         3'd1:    tx_byte = a_q[7:0];
         3'd2:    tx_byte = a_q[15:8];
         3'd3:    tx_byte = b_q[7:0];
         3'd4:    tx_byte = b_q[15:8];
         default: tx_byte = 8'h00;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      tx_idx_d    = tx_idx_q;
      tx_guard_d  = tx_guard_q;
      rx_idx_d    = rx_idx_q;
      rx_lo_d     = rx_lo_q;
      rx_hi_d     = rx_hi_q;
      idle_d      = idle_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      res_d       = res_q;
      overflow_d  = overflow_q;
      timeout_d   = timeout_q;
      proto_err_d = proto_err_q;
      txbuf_d     = txbuf_q;
      txstart_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d        = bus.op;
               a_d         = bus.a;
               b_d         = bus.b;
               timeout_d   = 1'b0;
               proto_err_d = 1'b0;
               tx_idx_d    = '0;
               busy_d      = 1'b1;
               state_d     = SEND;
            end
         end

         SEND: begin
            if (!bus.TXbusy) begin
               txbuf_d    = tx_byte;
               txstart_d  = 1'b1;
               tx_guard_d = TX_GUARD;
               state_d    = TXWAIT;
            end
         end

         // The UART raises TXbusy only after seeing TXstart, so its early value is stale.
         TXWAIT: begin
            if (tx_guard_q != '0) begin
               tx_guard_d = tx_guard_q - GUARD_W'(1);
            end else if (!bus.TXbusy) begin
               if (tx_idx_q == TX_LAST) begin
                  rx_idx_d = '0;
                  idle_d   = '0;
                  state_d  = RECV;
               end else begin
                  tx_idx_d = tx_idx_q + TX_IDX_W'(1);
                  state_d  = SEND;
               end
            end
         end

         // A byte arriving on the limit cycle takes priority over the timeout.
         RECV: begin
            if (bus.RXready) begin
               idle_d = '0;
               if (rx_idx_q == RX_LAST) begin
                  res_d       = {rx_hi_q, rx_lo_q};
                  overflow_d  = bus.RXbuffer[0];
                  proto_err_d = |bus.RXbuffer[7:1];
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = FINISH;
               end else begin
                  if (rx_idx_q == '0) begin
                     rx_lo_d = bus.RXbuffer;
                  end else begin
                     rx_hi_d = bus.RXbuffer;
                  end
                  rx_idx_d = rx_idx_q + RX_IDX_W'(1);
               end
            end else if (idle_q == IDLE_LIMIT) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = FINISH;
            end else begin
               idle_d = idle_q + CNT_W'(1);
            end
         end

         // Done-pulse cycle; a start seen here is deliberately not taken.
         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         tx_idx_q    <= '0;
         tx_guard_q  <= '0;
         rx_idx_q    <= '0;
         rx_lo_q     <= 8'h00;
         rx_hi_q     <= 8'h00;
         idle_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_q       <= 16'h0000;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
         proto_err_q <= 1'b0;
         txbuf_q     <= 8'h00;
         txstart_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tx_idx_q    <= tx_idx_d;
         tx_guard_q  <= tx_guard_d;
         rx_idx_q    <= rx_idx_d;
         rx_lo_q     <= rx_lo_d;
         rx_hi_q     <= rx_hi_d;
         idle_q      <= idle_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         res_q       <= res_d;
         overflow_q  <= overflow_d;
         timeout_q   <= timeout_d;
         proto_err_q <= proto_err_d;
         txbuf_q     <= txbuf_d;
         txstart_q   <= txstart_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res       = res_q;
   assign bus.overflow  = overflow_q;
   assign bus.timeout   = timeout_q;
   assign bus.proto_err = proto_err_q;
   assign bus.TXbuffer  = txbuf_q;
   assign bus.TXstart   = txstart_q;
endmodule
